// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared types and constants for the FIFO-to-UART drain stage
package fifo_uart_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 10;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read port (RD/EMPTY/dataOut) seen by the drain stage
interface fifo_uart_tx_if;

  logic       EMPTY;
  logic [7:0] fifoData;
  logic       RD;

  modport master (input EMPTY, input fifoData, output RD);
  modport slave  (output EMPTY, output fifoData, input RD);

endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// rtl/fifo_uart_tx_baud_tick_gen.sv - bit-period counter, tick on the last cycle of each bit
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = !clear && (cnt == LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops one FIFO byte per frame and serialises it as UART 8N1
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  EN,
  fifo_uart_tx_if.master        fifo,
  output logic                  TX,
  output logic                  BUSY
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state, state_nx;
  logic [7:0] shift, shift_nx;
  logic [2:0] bit_idx, bit_idx_nx;
  logic       tx_nx, rd_nx, busy_nx;
  logic       tick, clear, fetch_ok;

  assign fetch_ok = EN && !fifo.EMPTY;
  // Bit timer only runs while a frame is on the line; it sits at zero through the fetch gap.
  assign clear    = (state == IDLE) || (state == FETCH) || (state == LOAD);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    state_nx   = state;
    shift_nx   = shift;
    bit_idx_nx = bit_idx;
    case (state)
      IDLE:  if (fetch_ok) state_nx = FETCH;
      FETCH: state_nx = LOAD;
      LOAD: begin
        shift_nx   = fifo.fifoData;
        bit_idx_nx = '0;
        state_nx   = START;
      end
      START: if (tick) begin
        state_nx   = DATA;
        bit_idx_nx = '0;
      end
      DATA: if (tick) begin
        shift_nx = shift >> 1;
        if (bit_idx == LAST_BIT) state_nx = STOP;
        else                     bit_idx_nx = bit_idx + 3'd1;
      end
      STOP:    if (tick) state_nx = fetch_ok ? FETCH : IDLE;
      default: state_nx = IDLE;
    endcase

    // Outputs are decoded from the next state so TX/RD/BUSY come straight off flops.
    tx_nx = IDLE_LEVEL;
    case (state_nx)
      START:   tx_nx = ~IDLE_LEVEL;
      DATA:    tx_nx = shift_nx[0];
      default: tx_nx = IDLE_LEVEL;
    endcase
    rd_nx   = (state_nx == FETCH);
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      TX      <= IDLE_LEVEL;
      fifo.RD <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_nx;
      shift   <= shift_nx;
      bit_idx <= bit_idx_nx;
      TX      <= tx_nx;
      fifo.RD <= rd_nx;
      BUSY    <= busy_nx;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx with FIFO model and line decoder
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int CPB    = 4;
  localparam int PERIOD = FRAME_BITS * CPB + 2;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic EN = 1'b0;
  logic TX, BUSY;

  fifo_uart_tx_if ifc ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .EN    (EN),
    .fifo  (ifc.master),
    .TX    (TX),
    .BUSY  (BUSY)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rd_on_empty = 0;
  int rd_times[$];
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [9:0] dec_q[$];
  bit mon_en = 1'b1;

  always @(posedge Clk) cyc <= cyc + 1;

  // FIFO model: dataOut updates after the edge that sees RD, well before the drain captures it.
  initial begin
    ifc.EMPTY = 1'b1;
    ifc.fifoData = 8'h00;
    forever begin
      @(negedge Clk);
      if (ifc.RD === 1'b1) begin
        rd_times.push_back(cyc);
        if (fifo_q.size() > 0) ifc.fifoData = fifo_q.pop_front();
        else rd_on_empty++;
      end
      ifc.EMPTY = (fifo_q.size() == 0);
    end
  end

  // Line decoder: samples each bit mid-period, records {stop, data, start}.
  initial begin
    logic [7:0] b;
    logic st, sp;
    forever begin
      @(negedge Clk);
      if (mon_en && Rst_n && TX === 1'b0) begin
        repeat (CPB / 2) @(negedge Clk);
        st = TX;
        for (int i = 0; i < DATA_BITS; i++) begin
          repeat (CPB) @(negedge Clk);
          b[i] = TX;
        end
        repeat (CPB) @(negedge Clk);
        sp = TX;
        if (mon_en) dec_q.push_back({sp, b, st});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_rd(output int t);
    bit seen;
    seen = 1'b0;
    t = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge Clk);
      if (ifc.RD === 1'b1) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    chk("rd_seen", {31'd0, seen}, 32'd1);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == FRAME_BITS - 1) return 1'b1;
    return b[i - 1];
  endfunction

  initial begin
    int t, base;
    logic [7:0] rb;

    // Reset held with data available and enable high
    push(8'hA5);
    EN = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      chk("reset_tx", TX, 1);
      chk("reset_rd", ifc.RD, 0);
      chk("reset_busy", BUSY, 0);
    end
    Rst_n = 1'b1;

    // Single byte 0xA5 with exact cycle timing
    wait_rd(t);
    chk("busy_at_rd", BUSY, 1);
    for (int i = 1; i < 2 + FRAME_BITS * CPB; i++) begin
      @(negedge Clk);
      if (i == 1) begin
        chk("rd_one_cycle", ifc.RD, 0);
        chk("tx_gap", TX, 1);
      end else begin
        chk("a5_tx_bit", TX, frame_bit(8'hA5, (i - 2) / CPB));
      end
    end
    chk("busy_last_stop", BUSY, 1);
    @(negedge Clk);
    chk("busy_after_stop", BUSY, 0);
    chk("tx_idle", TX, 1);
    chk("a5_rd_count", rd_times.size(), 1);

    // Back-to-back 01..04
    EN = 1'b0;
    for (int k = 1; k <= 4; k++) push(8'(k));
    repeat (2) @(negedge Clk);
    base = rd_times.size();
    EN = 1'b1;
    repeat (4 * PERIOD + 30) @(negedge Clk);
    chk("b2b_rd_count", rd_times.size() - base, 4);
    for (int k = 1; k < 4; k++)
      if (base + k < rd_times.size())
        chk("b2b_rd_spacing", rd_times[base + k] - rd_times[base + k - 1], PERIOD);
    chk("b2b_busy_end", BUSY, 0);

    // EN gating with data waiting
    EN = 1'b0;
    push(8'($urandom));
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      chk("engate_rd", ifc.RD, 0);
      chk("engate_tx", TX, 1);
    end
    EN = 1'b1;
    @(negedge Clk);
    chk("engate_rd_next", ifc.RD, 1);
    repeat (PERIOD + 5) @(negedge Clk);

    // EN dropped mid-frame with a second byte queued
    EN = 1'b0;
    push(8'hAA);
    rb = 8'($urandom);
    push(rb);
    repeat (2) @(negedge Clk);
    EN = 1'b1;
    wait_rd(t);
    repeat (10) @(negedge Clk);
    EN = 1'b0;
    base = rd_times.size();
    repeat (2 * PERIOD) @(negedge Clk);
    chk("endrop_no_rd", rd_times.size() - base, 0);
    chk("endrop_busy", BUSY, 0);
    chk("endrop_empty", ifc.EMPTY, 0);
    EN = 1'b1;
    @(negedge Clk);
    chk("endrop_resume_rd", ifc.RD, 1);
    repeat (PERIOD + 5) @(negedge Clk);

    // Full drain of eight 0xAA
    EN = 1'b0;
    repeat (8) push(8'hAA);
    repeat (2) @(negedge Clk);
    base = rd_times.size();
    EN = 1'b1;
    repeat (8 * PERIOD + 20) @(negedge Clk);
    chk("drain_rd_count", rd_times.size() - base, 8);
    chk("drain_empty", ifc.EMPTY, 1);
    chk("drain_busy", BUSY, 0);
    chk("drain_tx", TX, 1);

    // Random bytes with random enable pauses
    for (int k = 0; k < 6; k++) begin
      push(8'($urandom));
      EN = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 20)) @(negedge Clk);
      EN = 1'b1;
      repeat (PERIOD + 5) @(negedge Clk);
    end
    chk("rand_busy", BUSY, 0);

    // Decoded frames against the byte order pushed into the FIFO
    chk("frame_count", dec_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < dec_q.size(); k++)
      chk("frame_byte", {22'd0, dec_q[k]}, {22'd0, 1'b1, exp_q[k], 1'b0});
    chk("rd_on_empty", rd_on_empty, 0);

    // Asynchronous reset in the middle of the start bit
    mon_en = 1'b0;
    push(8'h00);
    wait_rd(t);
    repeat (2) @(negedge Clk);
    chk("pre_reset_tx", TX, 0);
    #1 Rst_n = 1'b0;
    #1;
    chk("async_reset_tx", TX, 1);
    chk("async_reset_busy", BUSY, 0);
    chk("async_reset_rd", ifc.RD, 0);
    EN = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (5) @(negedge Clk);
    chk("post_reset_tx", TX, 1);
    chk("post_reset_busy", BUSY, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
